// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port round-robin arbiter in front of a single-port data
//            memory. The datapath (cpu) and the debug/loader port (dbg) share
//            one memory strobe. Grants are combinational in the request
//            cycle. Read data comes back one cycle later on the owner's
//            rvalid/rdata.
//            Optional feature macro: DMEM_ARB_LOCK_EN. It adds a dbg_lock
//            input that pins the memory to the debug port.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic              dbg_lock,
`endif

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [15:0]       conflict_cnt
);

    // Identity of the most recently granted requester
    localparam logic       c_GNT_CPU = 1'b0;
    localparam logic       c_GNT_DBG = 1'b1;
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic        r_last_gnt;
    logic        r_cpu_rvalid;
    logic        r_dbg_rvalid;
    logic [15:0] r_conflict_cnt;
    logic        w_locked;
    logic        w_both_req;
    logic        w_cpu_gnt;
    logic        w_dbg_gnt;

`ifdef DMEM_ARB_LOCK_EN
    localparam logic [0:0] c_ST_ARB    = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

    logic [0:0] r_state;

    // Lock FSM: the state follows dbg_lock sampled at each edge; reset returns to ARB
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_ARB;
        end else begin
            case (r_state)
                c_ST_ARB:    if (dbg_lock)  r_state <= c_ST_LOCKED;
                c_ST_LOCKED: if (!dbg_lock) r_state <= c_ST_ARB;
                default:                    r_state <= c_ST_ARB;
            endcase
        end
    end

    assign w_locked = (r_state == c_ST_LOCKED);
`else
    // Without the lock feature the arbiter never leaves round-robin mode
    assign w_locked = 1'b0;
`endif

    assign w_both_req = cpu_req & dbg_req;

    // On contention, grant the side that did not win last time. A lock hands
    // every cycle to dbg. Reset blocks all grants.
    assign w_cpu_gnt = ~reset & ~w_locked & cpu_req &
                       (~dbg_req | (r_last_gnt == c_GNT_DBG));
    assign w_dbg_gnt = ~reset & dbg_req &
                       (w_locked | ~cpu_req | (r_last_gnt == c_GNT_CPU));

    assign cpu_gnt = w_cpu_gnt;
    assign dbg_gnt = w_dbg_gnt;

    // Route the granted requester's fields to the memory; zero them when idle
    always_comb begin
        mem_en    = w_cpu_gnt | w_dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // Round-robin pointer: move on every granted cycle, hold when idle.
    // After reset it points at dbg, so cpu wins the first contended cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_gnt <= c_GNT_DBG;
        end else if (w_cpu_gnt) begin
            r_last_gnt <= c_GNT_CPU;
        end else if (w_dbg_gnt) begin
            r_last_gnt <= c_GNT_DBG;
        end
    end

    // Read-return tracking: a granted read raises its owner's rvalid next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
        end else begin
            r_cpu_rvalid <= w_cpu_gnt & ~cpu_we;
            r_dbg_rvalid <= w_dbg_gnt & ~dbg_we;
        end
    end

    // A reset arriving in the return cycle must hide a read that is in flight
    assign cpu_rvalid = r_cpu_rvalid & ~reset;
    assign dbg_rvalid = r_dbg_rvalid & ~reset;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

    // Saturating count of edges where both requesters were asking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_conflict_cnt <= '0;
        end else if (w_both_req && (r_conflict_cnt != c_CNT_MAX)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench for dmem_arbiter. It provides a behavioural
//            32-word memory, a table of directed vectors, hand-written reset,
//            saturation and lock sequences, and a randomized phase that is
//            checked against a round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NWORDS = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we, dbg_req, dbg_we;
    logic [ADDR_W-1:0] cpu_addr, dbg_addr;
    logic [DATA_W-1:0] cpu_wdata, dbg_wdata;
    logic              cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [DATA_W-1:0] cpu_rdata, dbg_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [15:0]       conflict_cnt;
`ifdef DMEM_ARB_LOCK_EN
    logic              dbg_lock;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata),
`ifdef DMEM_ARB_LOCK_EN
        .dbg_lock(dbg_lock),
`endif
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .conflict_cnt(conflict_cnt)
    );

    // Power-on memory image; word 2 holds 255
    function automatic logic [DATA_W-1:0] init_word(input int i);
        return (i == 2) ? 32'd255 : DATA_W'(i * 1000 + 13);
    endfunction

    // Behavioural synchronous memory. Reset reloads the image. On cycles
    // with no read the output carries junk, so ungated rdata shows up.
    logic [DATA_W-1:0] env_mem [NWORDS];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NWORDS; i++) env_mem[i] <= init_word(i);
            mem_rdata <= $urandom;
        end else begin
            if (mem_en && mem_we) env_mem[mem_addr] <= mem_wdata;
            if (mem_en && !mem_we) mem_rdata <= env_mem[mem_addr];
            else                   mem_rdata <= $urandom;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    // Hold reset with both requests active. No grant or count may appear.
    task automatic do_reset();
        idle_inputs();
        reset = 1; cpu_req = 1; dbg_req = 1;
`ifdef DMEM_ARB_LOCK_EN
        dbg_lock = 1;
`endif
        step(); step();
        @(negedge clk);
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_dbg_gnt", dbg_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rvalid", {cpu_rvalid, dbg_rvalid}, 0);
        chk("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
        chk("rst_cnt", conflict_cnt, 0);
        step();
        reset = 0;
        idle_inputs();
`ifdef DMEM_ARB_LOCK_EN
        dbg_lock = 0;
`endif
    endtask

    typedef struct {
        logic creq, cwe; logic [4:0] caddr; logic [31:0] cwd;
        logic dreq, dwe; logic [4:0] daddr; logic [31:0] dwd;
        logic ecg, edg, een, ewe; logic [4:0] eaddr; logic [31:0] ewd;
        logic ecrv, edrv; logic [31:0] ecrd, edrd;
    } vec_t;

    // Reference-model state for the random phase
    int                m_last;    // 0 = cpu won last, 1 = dbg won last
    bit                m_locked;
    int                m_cnt;
    bit                m_rv_c, m_rv_d;
    logic [DATA_W-1:0] m_rd;
    logic [DATA_W-1:0] m_mem [NWORDS];

    initial begin
        vec_t tbl [12];
        bit   c_pend, d_pend;
        bit   ecg, edg, nrv_c, nrv_d;
        logic [DATA_W-1:0] nrd;
        logic e_we; logic [4:0] e_addr; logic [31:0] e_wd;

        reset = 1;
        idle_inputs();
`ifdef DMEM_ARB_LOCK_EN
        dbg_lock = 0;
`endif
        //          creq cwe caddr cwd  dreq dwe daddr dwd   cg dg en we addr wd     crv drv crd drd
        tbl[0]  = '{1, 0, 5'd2, 32'd0,     0, 0, 5'd0, 32'd0,  1, 0, 1, 0, 5'd2, 32'd0,     0, 0, 32'd0,   32'd0};
        tbl[1]  = '{0, 0, 5'd0, 32'd0,     0, 0, 5'd0, 32'd0,  0, 0, 0, 0, 5'd0, 32'd0,     1, 0, 32'd255, 32'd0};
        tbl[2]  = '{0, 0, 5'd0, 32'd0,     1, 1, 5'd9, 32'd77, 0, 1, 1, 1, 5'd9, 32'd77,    0, 0, 32'd0,   32'd0};
        tbl[3]  = '{1, 0, 5'd9, 32'd0,     0, 0, 5'd0, 32'd0,  1, 0, 1, 0, 5'd9, 32'd0,     0, 0, 32'd0,   32'd0};
        tbl[4]  = '{0, 0, 5'd0, 32'd0,     0, 0, 5'd0, 32'd0,  0, 0, 0, 0, 5'd0, 32'd0,     1, 0, 32'd77,  32'd0};
        tbl[5]  = '{1, 0, 5'd2, 32'd0,     1, 0, 5'd9, 32'd0,  0, 1, 1, 0, 5'd9, 32'd0,     0, 0, 32'd0,   32'd0};
        tbl[6]  = '{1, 0, 5'd2, 32'd0,     1, 0, 5'd9, 32'd0,  1, 0, 1, 0, 5'd2, 32'd0,     0, 1, 32'd0,   32'd77};
        tbl[7]  = '{1, 0, 5'd2, 32'd0,     1, 0, 5'd9, 32'd0,  0, 1, 1, 0, 5'd9, 32'd0,     1, 0, 32'd255, 32'd0};
        tbl[8]  = '{1, 0, 5'd2, 32'd0,     1, 0, 5'd9, 32'd0,  1, 0, 1, 0, 5'd2, 32'd0,     0, 1, 32'd0,   32'd77};
        tbl[9]  = '{0, 0, 5'd0, 32'd0,     0, 0, 5'd0, 32'd0,  0, 0, 0, 0, 5'd0, 32'd0,     1, 0, 32'd255, 32'd0};
        tbl[10] = '{1, 1, 5'd3, 32'h1234,  1, 1, 5'd4, 32'd5,  0, 1, 1, 1, 5'd4, 32'd5,     0, 0, 32'd0,   32'd0};
        tbl[11] = '{0, 0, 5'd0, 32'd0,     0, 0, 5'd0, 32'd0,  0, 0, 0, 0, 5'd0, 32'd0,     0, 0, 32'd0,   32'd0};

        // ---------------- directed table ----------------
        do_reset();
        for (int r = 0; r < 12; r++) begin
            cpu_req = tbl[r].creq; cpu_we = tbl[r].cwe; cpu_addr = tbl[r].caddr; cpu_wdata = tbl[r].cwd;
            dbg_req = tbl[r].dreq; dbg_we = tbl[r].dwe; dbg_addr = tbl[r].daddr; dbg_wdata = tbl[r].dwd;
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", r), {cpu_gnt, dbg_gnt}, {tbl[r].ecg, tbl[r].edg});
            chk($sformatf("tbl%0d_mem_ctl", r), {mem_en, mem_we, mem_addr}, {tbl[r].een, tbl[r].ewe, tbl[r].eaddr});
            chk($sformatf("tbl%0d_mem_wdata", r), mem_wdata, tbl[r].ewd);
            chk($sformatf("tbl%0d_rvalid", r), {cpu_rvalid, dbg_rvalid}, {tbl[r].ecrv, tbl[r].edrv});
            chk($sformatf("tbl%0d_cpu_rdata", r), cpu_rdata, tbl[r].ecrd);
            chk($sformatf("tbl%0d_dbg_rdata", r), dbg_rdata, tbl[r].edrd);
            step();
        end
        idle_inputs();
        @(negedge clk);
        chk("tbl_conflict_cnt", conflict_cnt, 5);
        step();

        // ---------------- contention after reset: CPU,DBG,CPU,DBG ----------------
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cpu_req = 1; cpu_addr = 5'd1; dbg_req = 1; dbg_addr = 5'd3;
            @(negedge clk);
            chk($sformatf("rr%0d_gnt", i), {cpu_gnt, dbg_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
            step();
        end
        idle_inputs();
        @(negedge clk);
        chk("rr_conflict_cnt", conflict_cnt, 4);
        step();

        // ---------------- reset in the return cycle hides rvalid ----------------
        do_reset();
        cpu_req = 1; cpu_addr = 5'd2;
        @(negedge clk);
        chk("rstrd_gnt", cpu_gnt, 1);
        step();
        idle_inputs();
        reset = 1;
        @(negedge clk);
        chk("rstrd_rvalid_in_reset", cpu_rvalid, 0);
        chk("rstrd_rdata_in_reset", cpu_rdata, 0);
        step();
        reset = 0;
        @(negedge clk);
        chk("rstrd_rvalid_after", cpu_rvalid, 0);
        chk("rstrd_cnt", conflict_cnt, 0);
        step();

`ifdef DMEM_ARB_LOCK_EN
        // ---------------- lock hands memory to dbg ----------------
        do_reset();
        dbg_lock = 1;
        step();
        for (int i = 0; i < 3; i++) begin
            cpu_req = 1; cpu_addr = 5'd5; dbg_req = 1; dbg_addr = 5'd6;
            @(negedge clk);
            chk($sformatf("lock%0d_gnt", i), {cpu_gnt, dbg_gnt}, 2'b01);
            step();
        end
        idle_inputs();
        dbg_lock = 0;
        step();
        cpu_req = 1; cpu_addr = 5'd5; dbg_req = 1; dbg_addr = 5'd6;
        @(negedge clk);
        chk("unlock_gnt", {cpu_gnt, dbg_gnt}, 2'b10);
        chk("lock_cnt", conflict_cnt, 3);
        step();
        idle_inputs();
`endif

        // ---------------- randomized phase vs reference model ----------------
        do_reset();
        m_last = 1; m_locked = 0; m_cnt = 0; m_rv_c = 0; m_rv_d = 0; m_rd = '0;
        for (int i = 0; i < NWORDS; i++) m_mem[i] = init_word(i);
        c_pend = 0; d_pend = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            // A requester that was refused keeps its request unchanged
            if (!c_pend) begin
                cpu_req = ($urandom_range(0, 9) < 6); cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 5'($urandom); cpu_wdata = $urandom;
            end
            if (!d_pend) begin
                dbg_req = ($urandom_range(0, 9) < 6); dbg_we = 1'($urandom_range(0, 1));
                dbg_addr = 5'($urandom); dbg_wdata = $urandom;
            end
`ifdef DMEM_ARB_LOCK_EN
            if ($urandom_range(0, 15) == 0) dbg_lock = ~dbg_lock;
`endif
            if (m_locked) begin
                ecg = 0; edg = dbg_req;
            end else if (cpu_req && dbg_req) begin
                ecg = (m_last == 1); edg = !ecg;
            end else begin
                ecg = cpu_req; edg = dbg_req;
            end
            e_we = 0; e_addr = '0; e_wd = '0;
            if (ecg) begin e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata; end
            if (edg) begin e_we = dbg_we; e_addr = dbg_addr; e_wd = dbg_wdata; end

            @(negedge clk);
            chk("rnd_gnt", {cpu_gnt, dbg_gnt}, {ecg, edg});
            chk("rnd_mem_ctl", {mem_en, mem_we, mem_addr}, {ecg | edg, e_we, e_addr});
            chk("rnd_mem_wdata", mem_wdata, e_wd);
            chk("rnd_rvalid", {cpu_rvalid, dbg_rvalid}, {m_rv_c, m_rv_d});
            chk("rnd_cpu_rdata", cpu_rdata, m_rv_c ? m_rd : '0);
            chk("rnd_dbg_rdata", dbg_rdata, m_rv_d ? m_rd : '0);
            chk("rnd_cnt", conflict_cnt, m_cnt);

            @(posedge clk);
            nrv_c = 0; nrv_d = 0; nrd = m_rd;
            if (ecg) begin
                m_last = 0;
                if (cpu_we) m_mem[cpu_addr] = cpu_wdata;
                else begin nrv_c = 1; nrd = m_mem[cpu_addr]; end
            end
            if (edg) begin
                m_last = 1;
                if (dbg_we) m_mem[dbg_addr] = dbg_wdata;
                else begin nrv_d = 1; nrd = m_mem[dbg_addr]; end
            end
            m_rv_c = nrv_c; m_rv_d = nrv_d; m_rd = nrd;
            if (cpu_req && dbg_req && m_cnt < 65535) m_cnt++;
`ifdef DMEM_ARB_LOCK_EN
            m_locked = dbg_lock;
`endif
            c_pend = cpu_req && !ecg;
            d_pend = dbg_req && !edg;
            #1;
        end
        idle_inputs();
`ifdef DMEM_ARB_LOCK_EN
        dbg_lock = 0;
`endif
        step();

        // ---------------- counter saturation ----------------
        do_reset();
        cpu_req = 1; cpu_addr = 5'd7; dbg_req = 1; dbg_addr = 5'd8;
        for (int i = 0; i < 65534; i++) step();
        @(negedge clk);
        chk("sat_cnt_fffe", conflict_cnt, 16'hFFFE);
        step();
        @(negedge clk);
        chk("sat_cnt_ffff", conflict_cnt, 16'hFFFF);
        for (int i = 0; i < 4465; i++) step();
        @(negedge clk);
        chk("sat_cnt_hold", conflict_cnt, 16'hFFFF);
        chk("sat_one_gnt", 64'(cpu_gnt) + 64'(dbg_gnt), 1);
        step();
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, word address width (32-word data memory).
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL use a single clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cpu_req / cpu_we  input  1 / 1  datapath access request / write-enable.
REQ-007 cpu_addr / cpu_wdata  input  ADDR_W / DATA_W  datapath address / write data.
REQ-008 cpu_gnt / cpu_rvalid  output  1 / 1  datapath grant / read data valid.
REQ-009 cpu_rdata  output  DATA_W  datapath read data.
REQ-010 dbg_req / dbg_we  input  1 / 1  debug/loader request / write-enable.
REQ-011 dbg_addr / dbg_wdata  input  ADDR_W / DATA_W  debug address / write data.
REQ-012 dbg_gnt / dbg_rvalid  output  1 / 1  debug grant / read data valid.
REQ-013 dbg_rdata  output  DATA_W  debug read data.
REQ-014 mem_en / mem_we  output  1 / 1  memory access strobe / write strobe.
REQ-015 mem_addr / mem_wdata  output  ADDR_W / DATA_W  memory address / write data.
REQ-016 mem_rdata  input  DATA_W  memory read data, valid one cycle after a read strobe.
REQ-017 conflict_cnt  output  16  saturating count of cycles with both requests high.

Function
REQ-018 At most one grant per cycle; gnt is combinational from req and arbiter state, same cycle.
REQ-019 Single request: grant that requester. Both requesting: grant the requester NOT granted most recently (round-robin).
REQ-020 last_gnt pointer updates on the clock edge of every granted cycle; unchanged on idle cycles.
REQ-021 Granted cycle: mem_en=1, mem_we/mem_addr/mem_wdata = granted requester's fields. No grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-022 Requester holds req and fields stable until gnt sampled high; the access completes in the granted cycle.
REQ-023 Granted read (we=0): owner's rvalid=1 exactly one cycle later, other rvalid=0.
REQ-024 xxx_rdata = mem_rdata when xxx_rvalid=1, else 0.
REQ-025 Granted writes produce no rvalid.
REQ-026 Back-to-back grants allowed every cycle; reads in consecutive cycles yield consecutive rvalid pulses.
REQ-027 conflict_cnt increments when cpu_req&dbg_req at a clock edge; saturates at 16'hFFFF.
REQ-028 Only two requesters exist; no same-cycle address hazard is possible.

Reset
REQ-029 On reset: all gnt and rvalid = 0, all rdata = 0, conflict_cnt = 0, FSM = ARB.
REQ-030 On reset: last_gnt = DBG, so the first contended cycle grants CPU.
REQ-031 Reset asserted one cycle after a granted read suppresses that rvalid.
REQ-032 gnt and mem_en are forced to 0 while reset is high.

Configuration
REQ-033 Macro DMEM_ARB_LOCK_EN adds input dbg_lock (1 bit) and FSM states ARB and LOCKED.
REQ-034 With the macro: ARB->LOCKED when dbg_lock=1 at an edge; LOCKED->ARB when dbg_lock=0 at an edge.
REQ-035 With the macro, in LOCKED: cpu_gnt=0 always; dbg_req granted every cycle; conflict_cnt still counts.
REQ-036 With the macro: reset forces ARB regardless of dbg_lock.
REQ-037 Without the macro: no dbg_lock port; FSM permanently ARB; round-robin only.

Verification
REQ-038 Reset, then cpu_req=1 (read, addr 2), mem[2]=255 -> cpu_gnt=1 same cycle; next cycle cpu_rvalid=1, cpu_rdata=255.
REQ-039 After reset, both requests held 4 cycles -> grants CPU,DBG,CPU,DBG; conflict_cnt=4.
REQ-040 dbg write addr 9 data 77, then cpu read addr 9 -> cpu_rdata=77, dbg_rvalid never 1.
REQ-041 cpu read granted, reset next cycle -> cpu_rvalid stays 0; conflict_cnt=0.
REQ-042 Both requests held 70000 cycles -> conflict_cnt=16'hFFFF, no wrap.
REQ-043 (DMEM_ARB_LOCK_EN) dbg_lock=1 with both requests for 3 cycles -> dbg_gnt=1, cpu_gnt=0 each cycle; after lock drops, CPU wins the next contended cycle.
